// File: rtl/serial_arith_pkg.sv
// serial_arith_pkg: shared FSM states, carry seed and counter sizing for serial arithmetic
package serial_arith_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
  localparam logic CARRY_INIT_SUB = 1'b1;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) if ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: start/done operand bus; ovf exists only with SERIAL_SUBTRACTOR_OVF_EN
interface serial_subtractor_if #(parameter int WIDTH = 8) ();
  logic start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic busy;
  logic done;
  logic [WIDTH-1:0] diff;
  logic borrow;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic ovf;
`endif
  modport master(output start, a, b, input busy, done, diff, borrow
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    , ovf
`endif
  );
  modport slave(input start, a, b, output busy, done, diff, borrow
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    , ovf
`endif
  );
endinterface

// File: rtl/full_adder.sv
// full_adder: one-bit combinational full adder cell
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial LSB-first a-b; SERIAL_SUBTRACTOR_OVF_EN adds signed overflow flag
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic rst,
  serial_subtractor_if.slave bus
);
  localparam int CW = clog2(WIDTH);
  state_e state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d, r_q, r_d, diff_q, diff_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic c_q, c_d, borrow_q, borrow_d;
  logic s, c_nx, shift, load, last;
  full_adder u_fa (.a_i(sa_q[0]), .b_i(~sb_q[0]), .c_i(c_q), .s_o(s), .c_o(c_nx));
  // next state: load operands when idle or finishing, otherwise shift one bit per clock
  always_comb begin
    shift    = state_q == SHIFT;
    load     = bus.start && !shift;
    last     = shift && cnt_q == CW'(WIDTH - 1);
    state_d  = load ? SHIFT : last ? DONE : shift ? SHIFT : IDLE;
    sa_d     = load ? bus.a : shift ? sa_q >> 1 : sa_q;
    sb_d     = load ? bus.b : shift ? sb_q >> 1 : sb_q;
    c_d      = load ? CARRY_INIT_SUB : shift ? c_nx : c_q;
    cnt_d    = load ? '0 : shift ? cnt_q + 1'b1 : cnt_q;
    r_d      = shift ? {s, r_q[WIDTH-1:1]} : r_q;
    diff_d   = last ? r_d : diff_q;
    borrow_d = last ? ~c_nx : borrow_q;
  end
  // state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      r_q      <= '0;
      c_q      <= CARRY_INIT_SUB;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      r_q      <= r_d;
      c_q      <= c_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
    end
  end
  assign bus.busy   = shift;
  assign bus.done   = state_q == DONE;
  assign bus.diff   = diff_q;
  assign bus.borrow = borrow_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic ovf_q;
  // carry into the MSB is the carry register during the last shift
  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else if (last) ovf_q <= c_q ^ c_nx;
  end
  assign bus.ovf = ovf_q;
`endif
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: randomized and directed checks of serial_subtractor against an arithmetic model
module tb_serial_subtractor;
  logic clk = 0;
  logic rst = 1;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  serial_subtractor_if #(.WIDTH(8)) if8 ();
  serial_subtractor_if #(.WIDTH(4)) if4 ();
  serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));
  serial_subtractor #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input bit noisy);
    int busy_n;
    int t;
    logic [7:0] d;
    busy_n = 0;
    t = 0;
    d = a - b;
    if8.a = a;
    if8.b = b;
    if8.start = 1;
    @(negedge clk);
    if8.start = 0;
    while (!if8.done && t < 20) begin
      if (if8.busy) busy_n++;
      if (noisy) begin
        if8.a = 8'($urandom);
        if8.b = 8'($urandom);
        if8.start = 1'($urandom);
      end
      @(negedge clk);
      t++;
    end
    if8.start = 0;
    check("done8", 32'(if8.done), 1);
    check("busy_len", busy_n, 8);
    check("busy_done_excl", 32'(if8.busy), 0);
    check("diff8", 32'(if8.diff), 32'(d));
    check("borrow8", 32'(if8.borrow), 32'(a < b));
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    check("ovf8", 32'(if8.ovf), 32'((a[7] != b[7]) && (d[7] != a[7])));
`endif
    @(negedge clk);
    check("done_pulse", 32'(if8.done), 0);
    check("diff_hold", 32'(if8.diff), 32'(d));
  endtask

  initial begin
    logic [7:0] qa[4];
    logic [7:0] qb[4];
    int t;
    if8.start = 0; if8.a = 0; if8.b = 0;
    if4.start = 0; if4.a = 0; if4.b = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    check("rst_busy", 32'(if8.busy), 0);
    check("rst_done", 32'(if8.done), 0);
    check("rst_diff", 32'(if8.diff), 0);
    check("rst_borrow", 32'(if8.borrow), 0);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    check("rst_ovf", 32'(if8.ovf), 0);
`endif
    run8(8'd100, 8'd58, 0);
    run8(8'h05, 8'h09, 0);
    run8(8'h00, 8'h00, 0);
    run8(8'hFF, 8'h01, 0);
    run8(8'h80, 8'h01, 0);
    run8(8'h7F, 8'hFF, 0);
    run8(8'h10, 8'h01, 0);
    for (int i = 0; i < 30; i++) run8(8'($urandom), 8'($urandom), 1'(i % 2));
    // back-to-back with start held high, new operands presented in each DONE cycle
    for (int k = 0; k < 4; k++) begin
      qa[k] = 8'($urandom);
      qb[k] = 8'($urandom);
    end
    if8.a = qa[0];
    if8.b = qb[0];
    if8.start = 1;
    for (int k = 0; k < 4; k++) begin
      t = 0;
      @(negedge clk);
      while (!if8.done && t < 20) begin
        @(negedge clk);
        t++;
      end
      check("b2b_done", 32'(if8.done), 1);
      check("b2b_diff", 32'(if8.diff), 32'(8'(qa[k] - qb[k])));
      check("b2b_borrow", 32'(if8.borrow), 32'(qa[k] < qb[k]));
      if (k < 3) begin
        if8.a = qa[k+1];
        if8.b = qb[k+1];
      end else if8.start = 0;
    end
    @(negedge clk);
    // reset during the 4th shift cycle
    run8(8'h37, 8'h12, 0);
    if8.a = 8'h99; if8.b = 8'h11; if8.start = 1;
    @(negedge clk);
    if8.start = 0;
    repeat (3) @(negedge clk);
    check("mid_busy", 32'(if8.busy), 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("mrst_busy", 32'(if8.busy), 0);
    check("mrst_done", 32'(if8.done), 0);
    check("mrst_diff", 32'(if8.diff), 0);
    check("mrst_borrow", 32'(if8.borrow), 0);
    run8(8'h10, 8'h01, 0);
    // exhaustive sweep at WIDTH=4
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++) begin
        if4.a = 4'(a);
        if4.b = 4'(b);
        if4.start = 1;
        @(negedge clk);
        if4.start = 0;
        t = 0;
        while (!if4.done && t < 12) begin
          @(negedge clk);
          t++;
        end
        check("sweep_done", 32'(if4.done), 1);
        check("sweep_diff", 32'(if4.diff), 32'((a - b) & 15));
        check("sweep_borrow", 32'(if4.borrow), 32'(a < b));
        @(negedge clk);
      end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
